// File: rtl/iot_event_driver_pkg.sv
// Shared definitions for the IoT event driver: FSM encoding, event direction
// constants and the default counter width.
package iot_event_driver_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/event_gap_timer.sv
// 4-bit loadable down-counter that paces the idle cycles between events.
// expired marks the last cycle of the loaded interval.
module event_gap_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       expired
);

  logic [3:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= 4'd0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != 4'd0) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  // A count of 1 means this is the final gap cycle.
  assign expired = (count_reg <= 4'd1);

endmodule

// File: rtl/iot_event_driver.sv
// Event driver: walks a mirrored device count to a requested target, one
// change/on_off event at a time, taking the shorter way round the wrap.
module iot_event_driver
  import iot_event_driver_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] target_in,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic             hold,
  output logic             change,
  output logic             on_off,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count_mirror
);

  localparam logic [WIDTH-1:0] HALF    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       GAP_VAL = 4'(GAP);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mirror_reg, mirror_next;
  logic [WIDTH-1:0] target_reg, target_next;
  logic             dir_reg, dir_next;
  logic             gap_load;
  logic             gap_expired;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] stepped;

  assign diff    = target_in - mirror_reg;
  assign stepped = (dir_reg == DIR_UP) ? (mirror_reg + ONE) : (mirror_reg - ONE);

  event_gap_timer u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (gap_load),
    .load_value (GAP_VAL),
    .expired    (gap_expired)
  );

  always_comb begin
    state_next  = state_reg;
    mirror_next = mirror_reg;
    target_next = target_reg;
    dir_next    = dir_reg;
    gap_load    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (target_valid) begin
          target_next = target_in;
          if (diff == '0) begin
            state_next = ST_DONE;
          end else begin
            // Exactly half-way round resolves upward.
            dir_next   = (diff <= HALF) ? DIR_UP : DIR_DOWN;
            state_next = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        if (!hold) begin
          mirror_next = stepped;
          if (stepped == target_reg) begin
            state_next = ST_DONE;
          end else if (GAP_VAL != 4'd0) begin
            gap_load   = 1'b1;
            state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_expired) begin
          state_next = ST_STEP;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      mirror_reg <= '0;
      target_reg <= '0;
      dir_reg    <= DIR_DOWN;
    end else begin
      state_reg  <= state_next;
      mirror_reg <= mirror_next;
      target_reg <= target_next;
      dir_reg    <= dir_next;
    end
  end

  // change is combinational from hold so the monitor sees it the same cycle.
  assign change       = (state_reg == ST_STEP) && !hold && !rst;
  assign on_off       = dir_reg;
  assign target_ready = (state_reg == ST_IDLE);
  assign busy         = (state_reg == ST_STEP) || (state_reg == ST_GAP);
  assign done         = (state_reg == ST_DONE);
  assign count_mirror = mirror_reg;

endmodule

// File: tb/tb_iot_event_driver.sv
// Directed bench for iot_event_driver: one instance with no gap, one with a
// 2-cycle gap, each paired with a behavioural up/down monitor.
module tb_iot_event_driver;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, tv0 = 1'b0, hold0 = 1'b0;
  logic [7:0] tgt0 = 8'd0;
  logic       ready0, change0, on_off0, busy0, done0;
  logic [7:0] count_mirror0;

  logic       rst2 = 1'b1, tv2 = 1'b0, hold2 = 1'b0;
  logic [7:0] tgt2 = 8'd0;
  logic       ready2, change2, on_off2, busy2, done2;
  logic [7:0] count_mirror2;

  logic [7:0] mon0, mon2;

  int checks = 0;
  int fails  = 0;

  iot_event_driver #(.WIDTH(8), .GAP(0)) dut0 (
    .clk(clk), .rst(rst0), .target_in(tgt0), .target_valid(tv0),
    .target_ready(ready0), .hold(hold0), .change(change0), .on_off(on_off0),
    .busy(busy0), .done(done0), .count_mirror(count_mirror0)
  );

  iot_event_driver #(.WIDTH(8), .GAP(2)) dut2 (
    .clk(clk), .rst(rst2), .target_in(tgt2), .target_valid(tv2),
    .target_ready(ready2), .hold(hold2), .change(change2), .on_off(on_off2),
    .busy(busy2), .done(done2), .count_mirror(count_mirror2)
  );

  // Behavioural up/down monitors sharing clk and rst with each driver.
  always @(posedge clk) begin
    if (rst0) mon0 <= 8'd0;
    else if (change0) mon0 <= on_off0 ? mon0 + 8'd1 : mon0 - 8'd1;
    if (rst2) mon2 <= 8'd0;
    else if (change2) mon2 <= on_off2 ? mon2 + 8'd1 : mon2 - 8'd1;
  end

  // Stimulus helper: hands a target to dut0 and watches until done.
  task automatic run_job0(input logic [7:0] t, output int n_ev, output int n_up,
                          output int n_cyc, output bit got_done, output bit saw_255,
                          output bit ready_in_job);
    n_ev = 0; n_up = 0; n_cyc = 0; got_done = 0; saw_255 = 0; ready_in_job = 0;
    @(negedge clk);
    tgt0 = t; tv0 = 1'b1;
    @(negedge clk);
    tv0 = 1'b0;
    for (int k = 0; k < 600; k++) begin
      #1;
      n_cyc = k + 1;
      if (change0) begin
        n_ev++;
        if (on_off0) n_up++;
      end
      if (count_mirror0 == 8'hff) saw_255 = 1;
      if (done0) begin
        got_done = 1;
        break;
      end
      if (ready0) ready_in_job = 1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst2 = 1'b1; hold0 = 1'b1; hold2 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (change0 !== 1'b0) begin fails++; $display("FAIL reset_change: got %b expected 0", change0); end
    checks++; if (on_off0 !== 1'b0) begin fails++; $display("FAIL reset_on_off: got %b expected 0", on_off0); end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b expected 00", busy0, done0); end
    checks++; if (count_mirror0 !== 8'd0) begin fails++; $display("FAIL reset_mirror: got %0d expected 0", count_mirror0); end
    @(negedge clk);
    rst0 = 1'b0; rst2 = 1'b0; hold0 = 1'b0;
    @(negedge clk); #1;
    checks++; if (ready0 !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready0); end
    checks++; if (ready2 !== 1'b1) begin fails++; $display("FAIL reset_ready_gap: got %b expected 1", ready2); end
    $display("test_reset done");
  endtask

  task automatic test_count_up();
    int n_ev, n_up, n_cyc; bit gd, s255, rij;
    run_job0(8'd5, n_ev, n_up, n_cyc, gd, s255, rij);
    checks++; if (gd !== 1'b1 || n_cyc != 6) begin fails++; $display("FAIL up5_latency: got done=%0d cycles=%0d expected done=1 cycles=6", gd, n_cyc); end
    checks++; if (n_ev != 5 || n_up != 5) begin fails++; $display("FAIL up5_events: got %0d events %0d up expected 5/5", n_ev, n_up); end
    checks++; if (count_mirror0 !== 8'd5) begin fails++; $display("FAIL up5_mirror: got %0d expected 5", count_mirror0); end
    checks++; if (rij !== 1'b0) begin fails++; $display("FAIL up5_ready_busy: got ready during job expected none"); end
    $display("test_count_up: target 5 events=%0d cycles=%0d", n_ev, n_cyc);
  endtask

  task automatic test_wrap_down();
    int n_ev, n_up, n_cyc; bit gd, s255, rij;
    run_job0(8'd250, n_ev, n_up, n_cyc, gd, s255, rij);
    checks++; if (n_ev != 11 || n_up != 0) begin fails++; $display("FAIL wrap_events: got %0d events %0d up expected 11/0", n_ev, n_up); end
    checks++; if (gd !== 1'b1 || n_cyc != 12) begin fails++; $display("FAIL wrap_latency: got done=%0d cycles=%0d expected done=1 cycles=12", gd, n_cyc); end
    checks++; if (s255 !== 1'b1) begin fails++; $display("FAIL wrap_pass_255: got not seen expected seen"); end
    checks++; if (count_mirror0 !== 8'd250) begin fails++; $display("FAIL wrap_mirror: got %0d expected 250", count_mirror0); end
    checks++; if (mon0 !== 8'd250) begin fails++; $display("FAIL wrap_monitor: got %0d expected 250", mon0); end
    $display("test_wrap_down: 5->250 events=%0d", n_ev);
  endtask

  task automatic test_tie();
    int n_ev, n_up, n_cyc; bit gd, s255, rij;
    run_job0(8'd0, n_ev, n_up, n_cyc, gd, s255, rij);
    checks++; if (n_ev != 6 || n_up != 6 || count_mirror0 !== 8'd0) begin fails++; $display("FAIL wrap_up_to_0: got %0d events %0d up mirror %0d expected 6/6/0", n_ev, n_up, count_mirror0); end
    run_job0(8'd128, n_ev, n_up, n_cyc, gd, s255, rij);
    checks++; if (n_ev != 128 || n_up != 128) begin fails++; $display("FAIL tie_events: got %0d events %0d up expected 128/128", n_ev, n_up); end
    checks++; if (gd !== 1'b1 || n_cyc != 129) begin fails++; $display("FAIL tie_latency: got done=%0d cycles=%0d expected done=1 cycles=129", gd, n_cyc); end
    checks++; if (mon0 !== 8'd128) begin fails++; $display("FAIL tie_monitor: got %0d expected 128", mon0); end
    run_job0(8'd7, n_ev, n_up, n_cyc, gd, s255, rij);
    checks++; if (n_ev != 121 || n_up != 0 || count_mirror0 !== 8'd7) begin fails++; $display("FAIL down_135: got %0d events %0d up mirror %0d expected 121/0/7", n_ev, n_up, count_mirror0); end
    $display("test_tie: 0->128 events=%0d", n_ev);
  endtask

  task automatic test_zero_distance();
    int n_ev, n_up, n_cyc; bit gd, s255, rij;
    run_job0(8'd7, n_ev, n_up, n_cyc, gd, s255, rij);
    checks++; if (gd !== 1'b1 || n_cyc != 1) begin fails++; $display("FAIL zero_done: got done=%0d cycles=%0d expected done=1 cycles=1", gd, n_cyc); end
    checks++; if (n_ev != 0) begin fails++; $display("FAIL zero_change: got %0d events expected 0", n_ev); end
    checks++; if (ready0 !== 1'b0) begin fails++; $display("FAIL zero_ready_in_done: got %b expected 0", ready0); end
    @(negedge clk); #1;
    checks++; if (ready0 !== 1'b1 || done0 !== 1'b0) begin fails++; $display("FAIL zero_ready_after: got ready=%b done=%b expected 1/0", ready0, done0); end
    $display("test_zero_distance: 7->7 cycles=%0d", n_cyc);
  endtask

  task automatic test_gap_hold();
    int ev_at[$];
    int done_at = -1;
    bit gap_ok = 1;
    @(negedge clk);
    tgt2 = 8'd3; tv2 = 1'b1;
    @(negedge clk);
    tv2 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      hold2 = (k < 3);
      #1;
      if (change2) ev_at.push_back(k);
      if ((k == 4 || k == 5 || k == 7 || k == 8) && (busy2 !== 1'b1 || change2 !== 1'b0)) gap_ok = 0;
      if (done2) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
    hold2 = 1'b0;
    checks++; if (ev_at.size() != 3) begin fails++; $display("FAIL gap_event_count: got %0d expected 3", ev_at.size()); end
    else begin
      checks++; if (ev_at[0] != 3 || ev_at[1] != 6 || ev_at[2] != 9) begin fails++; $display("FAIL gap_event_spacing: got %0d,%0d,%0d expected 3,6,9", ev_at[0], ev_at[1], ev_at[2]); end
    end
    checks++; if (done_at != 10) begin fails++; $display("FAIL gap_done: got cycle %0d expected 10", done_at); end
    checks++; if (gap_ok !== 1'b1) begin fails++; $display("FAIL gap_idle_cycles: got event or not busy in gap expected quiet busy"); end
    checks++; if (count_mirror2 !== 8'd3 || mon2 !== 8'd3) begin fails++; $display("FAIL gap_mirror: got %0d monitor %0d expected 3/3", count_mirror2, mon2); end
    $display("test_gap_hold: target 3 events=%0d done_cycle=%0d", ev_at.size(), done_at);
  endtask

  task automatic test_mid_reset();
    int n_ev, n_up, n_cyc; bit gd, s255, rij;
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    tgt0 = 8'd100; tv0 = 1'b1;
    @(negedge clk);
    tv0 = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    checks++; if (count_mirror0 !== 8'd40 || busy0 !== 1'b1) begin fails++; $display("FAIL midrst_progress: got mirror %0d busy %b expected 40/1", count_mirror0, busy0); end
    rst0 = 1'b1;
    #1;
    checks++; if (change0 !== 1'b0) begin fails++; $display("FAIL midrst_change: got %b expected 0", change0); end
    @(negedge clk); #1;
    checks++; if (count_mirror0 !== 8'd0 || busy0 !== 1'b0 || change0 !== 1'b0) begin fails++; $display("FAIL midrst_state: got mirror %0d busy %b change %b expected 0/0/0", count_mirror0, busy0, change0); end
    rst0 = 1'b0;
    @(negedge clk); #1;
    checks++; if (ready0 !== 1'b1 || mon0 !== 8'd0) begin fails++; $display("FAIL midrst_ready: got ready %b monitor %0d expected 1/0", ready0, mon0); end
    run_job0(8'd2, n_ev, n_up, n_cyc, gd, s255, rij);
    checks++; if (n_ev != 2 || count_mirror0 !== 8'd2 || mon0 !== 8'd2 || n_cyc != 3) begin fails++; $display("FAIL midrst_new_job: got %0d events mirror %0d monitor %0d cycles %0d expected 2/2/2/3", n_ev, count_mirror0, mon0, n_cyc); end
    $display("test_mid_reset: new job events=%0d", n_ev);
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_down();
    test_tie();
    test_zero_distance();
    test_gap_hold();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iot_event_driver.md
# iot_event_driver

Transmit side of the active-device event interface. Accepts a target device count over a valid/ready handshake and emits single-cycle `change`/`on_off` events until a mirrored count equals the target. Steps the shortest way round the 8-bit wrap. Drives the up/down device monitor in the IoT test harness; its mirror tracks the monitor's counter exactly when both share `clk`/`rst`.

## Interface

- `WIDTH`, 8: counter width; mirror and target wrap modulo 2^WIDTH.
- `GAP`, 0: idle cycles inserted between consecutive events of one job (0..15).

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `target_in`  in  WIDTH  requested device count.
- `target_valid`  in  1  target_in valid.
- `target_ready`  out  1  driver can accept a target (high only in IDLE).
- `hold`  in  1  suppresses event emission while high.
- `change`  out  1  event strobe to monitor.
- `on_off`  out  1  event direction: 1 = device on (count up), 0 = off (count down).
- `busy`  out  1  job in progress (state STEP or GAP).
- `done`  out  1  one-cycle pulse on job completion.
- `count_mirror`  out  WIDTH  driver's copy of the monitor count.

## Operation

- States: IDLE, STEP, GAP, DONE.
- IDLE:
  - `target_ready`=1.
  - On `target_valid && target_ready`, latch target.
  - diff = (target − mirror) mod 2^WIDTH.
  - diff==0 → DONE.
  - diff in 1..2^(WIDTH−1) → dir=up, go to STEP.
  - Otherwise → dir=down, go to STEP.
  - Tie (diff = 128) goes up.
  - Direction is fixed for the whole job.
- STEP:
  - `change` = !hold (combinational from hold); `on_off` = dir.
  - When hold=0, mirror ← mirror±1 (wrapping) at that edge.
  - Next state: DONE if the new mirror == target; else GAP if GAP>0; else stay in STEP.
  - hold=1: no event, mirror unchanged, stay in STEP.
- GAP:
  - `change`=0.
  - Gap counter loaded with GAP on entry and decremented each cycle, independent of hold.
  - Return to STEP after exactly GAP cycles.
- DONE: `done`=1 for one cycle, `target_ready`=0, then IDLE.
- `on_off` when `change`=0: holds the latched dir.
- `target_valid` outside IDLE is ignored; no buffering.

## Timing

- Reset values:
  - state IDLE, mirror 0, dir 0, gap counter 0.
  - `change`=0, `on_off`=0, `busy`=0, `done`=0.
  - `target_ready`=1 from the first cycle after rst deasserts.
- While rst is high, `change`=0 regardless of state or hold.
- rst mid-job aborts immediately: no further events, mirror 0. This stays consistent with a monitor on the same rst.
- Latency:
  - Target accepted at edge E0 → first event in the cycle after E0.
  - Job of distance N with no hold: N event cycles, plus (N−1)·GAP gap cycles, plus 1 DONE cycle.
- Every event cycle has `change`=1 for exactly one cycle. The mirror and the monitor update on the same edge.
- `count_mirror` is registered; it shows the post-event value in the cycle after each event.
- Accept and zero-distance job: `done` asserted the cycle after acceptance, with no `change` pulse.

## Structure

- Shared package:
  - state encoding constants (IDLE/STEP/GAP/DONE);
  - direction constants (DIR_UP=1, DIR_DOWN=0);
  - default WIDTH.
- Sub-module `event_gap_timer`: 4-bit loadable down-counter.
  - Inputs: load, load value GAP.
  - Output: expired.
  - Used by the GAP state.
- Top level holds the FSM, mirror register, target/dir latches and the wrap-aware difference logic.

## Test plan

- GAP=0, after reset, target 5 → `change`=1 for 5 consecutive cycles with `on_off`=1; mirror ends at 5; `done` on the following cycle.
- Mirror 5, target 250 → diff 245, so 11 down events (`on_off`=0); mirror passes 0→255 and ends at 250; paired monitor reads 250.
- Mirror 0, target 128 → tie resolves up; 128 up events; `done` after the 128th.
- Target equal to mirror (e.g. 7→7) → no `change` pulse; `done` one cycle after acceptance; `target_ready` high again the next cycle.
- GAP=2, target 3 from 0, hold high for 3 cycles in the first STEP cycles → events suppressed while hold is high; afterwards events are spaced exactly 3 cycles apart; 3 events total; mirror 3.
- rst asserted mid-job at mirror 40 of target 100 → `change` 0 that cycle and after; mirror 0, `busy` 0, `target_ready` 1 once rst deasserts; a new target is accepted normally.
